// File: rtl/dmem_responder.sv
// Purpose: word-organised single-port data memory answering the dmem_* request bus.
// Latency: LATENCY cycles from request sample to a one-cycle dmem_resp_o pulse.
// Backpressure: none; one request in flight, requests seen during WAIT are ignored.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dmem_addr_i            byte address; word index is dmem_addr_i[2 +: $clog2(DEPTH_WORDS)]
//   dmem_rmask_i           nonzero marks a read request
//   dmem_wmask_i           byte write enables; nonzero marks a write request
//   dmem_wdata_i           word-aligned write data
//   dmem_rdata_o           full word read, valid with dmem_resp_o, held until next commit
//   dmem_resp_o            one-cycle response pulse
//   dmem_err_o             qualifies dmem_resp_o: address beyond DEPTH_WORDS
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] dmem_addr_i,
  input  logic [3:0]  dmem_rmask_i,
  input  logic [3:0]  dmem_wmask_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_resp_o,
  output logic        dmem_err_o
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam int          CW      = $clog2(LATENCY + 1);
  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [29:0]   word_q;
  logic [3:0]    rmask_q;
  logic [3:0]    wmask_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          resp_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          sample;
  logic          req_live;
  logic          commit;
  logic [29:0]   word_d;
  logic [3:0]    rmask_d;
  logic [3:0]    wmask_d;
  logic [31:0]   wdata_d;
  logic          oor_d;
  logic [AW-1:0] idx_d;
  logic [31:0]   rd_word_d;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^dmem_addr_i[1:0];

  // The request acted on at the commit edge comes straight from the bus when
  // LATENCY is 1 (sample and commit are the same edge), otherwise from the latches.
  always_comb begin
    sample   = (state_q != WAIT);
    req_live = |(dmem_rmask_i | dmem_wmask_i);
    if (sample) begin
      word_d  = dmem_addr_i[31:2];
      rmask_d = dmem_rmask_i;
      wmask_d = dmem_wmask_i;
      wdata_d = dmem_wdata_i;
    end else begin
      word_d  = word_q;
      rmask_d = rmask_q;
      wmask_d = wmask_q;
      wdata_d = wdata_q;
    end
    // Gated by reset so a request held on the bus during reset never writes.
    commit    = rst_ni && (sample ? (req_live && (LATENCY == 1))
                                  : (cnt_q == CW'(1)));
    oor_d     = ({2'b00, word_d} >= DEPTH_U);
    idx_d     = word_d[AW-1:0];
    // Read of the pre-write word: the array updates non-blocking on the same edge.
    rd_word_d = (!oor_d && (|rmask_d)) ? mem[idx_d] : 32'h0;
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (commit && !oor_d) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_d[b]) mem[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (req_live) begin
            word_q  <= dmem_addr_i[31:2];
            rmask_q <= dmem_rmask_i;
            wmask_q <= dmem_wmask_i;
            wdata_q <= dmem_wdata_i;
            if (LATENCY == 1) begin
              state_q <= RESP;
              cnt_q   <= '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CW'(LATENCY - 1);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          // Counter is at least 1 throughout WAIT, so it cannot wrap.
          if (cnt_q == CW'(1)) begin
            state_q <= RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        resp_q  <= 1'b1;
        err_q   <= oor_d;
        rdata_q <= rd_word_d;
      end
    end
  end

  assign dmem_rdata_o = rdata_q;
  assign dmem_resp_o  = resp_q;
  assign dmem_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: self-checking bench for dmem_responder at LATENCY 1, 2 and 4.
// Latency: checks every response arrives exactly LATENCY cycles after its request.
// Backpressure: none in the DUT; the bench issues the next request in the RESP cycle.
module tb_dmem_responder;

  logic        clk;
  logic [31:0] addr_s  [3];
  logic [3:0]  rm_s    [3];
  logic [3:0]  wm_s    [3];
  logic [31:0] wd_s    [3];
  logic        rst_s   [3];
  logic [31:0] rdata_o [3];
  logic        resp_o  [3];
  logic        err_o   [3];

  int total = 0;
  int bad   = 0;

  // Reference storage: word contents plus which bytes have ever been written.
  logic [31:0] mdl [3][256];
  logic [3:0]  kb  [3][256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_s[g]),
      .dmem_addr_i (addr_s[g]),
      .dmem_rmask_i(rm_s[g]),
      .dmem_wmask_i(wm_s[g]),
      .dmem_wdata_i(wd_s[g]),
      .dmem_rdata_o(rdata_o[g]),
      .dmem_resp_o (resp_o[g]),
      .dmem_err_o  (err_o[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h", nm, d, act, exp);
    end
  endtask

  function automatic void model(input int d, input logic [31:0] a, input logic [3:0] rm,
                                input logic [3:0] wm, input logic [31:0] wd,
                                output logic [31:0] erd, output logic eer, output bit ekn);
    int w;
    w   = int'(a[31:2]);
    erd = 32'h0;
    eer = 1'b0;
    ekn = 1'b1;
    if (a[31:2] >= 30'd256) begin
      eer = 1'b1;
      return;
    end
    if (rm != 4'h0) begin
      erd = mdl[d][w];
      ekn = (kb[d][w] == 4'hF);
    end
    for (int b = 0; b < 4; b++) begin
      if (wm[b]) begin
        mdl[d][w][8*b +: 8] = wd[8*b +: 8];
        kb[d][w][b] = 1'b1;
      end
    end
  endfunction

  // Called at a negedge; presents the request, waits (bounded) for the response
  // and returns at the negedge inside the RESP cycle.
  task automatic txn(input int d, input logic [31:0] a, input logic [3:0] rm,
                     input logic [3:0] wm, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er);
    logic glitch;
    addr_s[d] = a; rm_s[d] = rm; wm_s[d] = wm; wd_s[d] = wd;
    @(posedge clk); #1;
    addr_s[d] = $urandom; rm_s[d] = 4'h0; wm_s[d] = 4'h0; wd_s[d] = $urandom;
    lat = 0; rd = 32'h0; er = 1'b0; glitch = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_o[d]) begin
        lat = c; rd = rdata_o[d]; er = err_o[d];
        break;
      end
      if (err_o[d]) glitch = 1'b1;
    end
    chk("err_outside_resp", d, {31'b0, glitch}, 32'h0);
  endtask

  task automatic mtxn(input int d, input logic [31:0] a, input logic [3:0] rm,
                      input logic [3:0] wm, input logic [31:0] wd);
    logic [31:0] erd, ard;
    logic        eer, aer;
    bit          ekn;
    int          lat;
    model(d, a, rm, wm, wd, erd, eer, ekn);
    txn(d, a, rm, wm, wd, lat, ard, aer);
    chk("latency", d, lat, lat_of(d));
    chk("err", d, {31'b0, aer}, {31'b0, eer});
    if (ekn) chk("rdata", d, ard, erd);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eer;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] trd, ard;
    logic        ter, aer;
    bit          tkn;
    int          lat;
    logic        seen;
    logic [31:0] b2b [3];

    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 256; w++) begin
        mdl[d][w] = 32'h0;
        kb[d][w]  = 4'h0;
      end
      rst_s[d] = 1'b0; addr_s[d] = 32'h0; rm_s[d] = 4'h0; wm_s[d] = 4'h0; wd_s[d] = 32'h0;
    end

    tbl[0]  = '{32'h0000_0004, 4'h0, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{32'h0000_0004, 4'hF, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{32'h0000_0008, 4'h0, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0};
    tbl[3]  = '{32'h0000_0008, 4'h0, 4'h4, 32'h00AA_0000, 32'h0000_0000, 1'b0};
    tbl[4]  = '{32'h0000_0008, 4'hF, 4'h0, 32'h0000_0000, 32'h11AA_3344, 1'b0};
    tbl[5]  = '{32'h0000_0000, 4'h0, 4'hF, 32'h0000_0005, 32'h0000_0000, 1'b0};
    tbl[6]  = '{32'h0000_0400, 4'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[7]  = '{32'h0000_0400, 4'hF, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[8]  = '{32'h0000_0000, 4'hF, 4'h0, 32'h0000_0000, 32'h0000_0005, 1'b0};
    tbl[9]  = '{32'h0000_0000, 4'hF, 4'hF, 32'h0000_0009, 32'h0000_0005, 1'b0};
    tbl[10] = '{32'h0000_0000, 4'hF, 4'h0, 32'h0000_0000, 32'h0000_0009, 1'b0};
    tbl[11] = '{32'h0000_0006, 4'h1, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{32'hFFFF_FFFC, 4'hF, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[13] = '{32'h0000_03FC, 4'h0, 4'hF, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    tbl[14] = '{32'h0000_03FF, 4'hF, 4'h0, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_resp", d, {31'b0, resp_o[d]}, 32'h0);
      chk("reset_err", d, {31'b0, err_o[d]}, 32'h0);
      chk("reset_rdata", d, rdata_o[d], 32'h0);
    end
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b1;
    @(negedge clk);

    // Directed table on the LATENCY=2 instance.
    for (int i = 0; i < 15; i++) begin
      model(1, tbl[i].addr, tbl[i].rm, tbl[i].wm, tbl[i].wd, trd, ter, tkn);
      txn(1, tbl[i].addr, tbl[i].rm, tbl[i].wm, tbl[i].wd, lat, ard, aer);
      chk($sformatf("tbl%0d_latency", i), 1, lat, 2);
      chk($sformatf("tbl%0d_err", i), 1, {31'b0, aer}, {31'b0, tbl[i].eer});
      chk($sformatf("tbl%0d_rdata", i), 1, ard, tbl[i].erd);
    end

    // Back-to-back reads at LATENCY=1: resp stays high three cycles.
    b2b[0] = 32'h0A0A_0A0A; b2b[1] = 32'h1B1B_1B1B; b2b[2] = 32'h2C2C_2C2C;
    for (int k = 0; k < 3; k++) mtxn(0, 32'(4 * k), 4'h0, 4'hF, b2b[k]);
    for (int k = 0; k < 3; k++) begin
      addr_s[0] = 32'(4 * k); rm_s[0] = 4'hF;
      @(negedge clk);
      chk($sformatf("b2b%0d_resp", k), 0, {31'b0, resp_o[0]}, 32'h1);
      chk($sformatf("b2b%0d_rdata", k), 0, rdata_o[0], b2b[k]);
    end
    rm_s[0] = 4'h0;
    @(negedge clk);
    chk("b2b_end_resp", 0, {31'b0, resp_o[0]}, 32'h0);

    // Reset during WAIT at LATENCY=4 drops the write.
    mtxn(2, 32'h10, 4'h0, 4'hF, 32'h1234_5678);
    addr_s[2] = 32'h10; wm_s[2] = 4'hF; wd_s[2] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    wm_s[2] = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_s[2] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_o[2]) seen = 1'b1;
      if (c == 2) rst_s[2] = 1'b1;
    end
    chk("rst_wait_no_resp", 2, {31'b0, seen}, 32'h0);
    mtxn(2, 32'h10, 4'hF, 4'h0, 32'h0);

    // Reset during RESP drops resp at once; the committed write stands.
    mtxn(1, 32'h20, 4'h0, 4'hF, 32'h0BAD_F00D);
    #1 rst_s[1] = 1'b0;
    #1;
    chk("rst_resp_low", 1, {31'b0, resp_o[1]}, 32'h0);
    chk("rst_resp_rdata", 1, rdata_o[1], 32'h0);
    @(negedge clk);
    rst_s[1] = 1'b1;
    @(negedge clk);
    mtxn(1, 32'h20, 4'hF, 4'h0, 32'h0);

    // Randomised traffic against the reference model.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        logic [31:0] w, a;
        logic [3:0]  rm, wm;
        w = (($urandom % 8) == 0) ? 32'(256 + $urandom_range(0, 1000)) : 32'($urandom_range(0, 15));
        a = {w[29:0], 2'($urandom)};
        rm = 4'($urandom); wm = 4'($urandom);
        if ((rm | wm) == 4'h0) rm = 4'hF;
        mtxn(d, a, rm, wm, $urandom);
      end
      @(negedge clk);
      chk("pulse_one_cycle", d, {31'b0, resp_o[d]}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the memory-side end of the `dmem_*` interface driven by the MEM stage and consumed by the WB stage. It accepts one read or write request at a time, waits a fixed, programmable latency and returns `dmem_resp` together with the full 32-bit `dmem_rdata` word. Lane extraction and sign extension of that word stay in WB. The block serves as the single-port, word-organised backing store for pipeline bring-up and random-latency testing.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of 2, ≥ 2.
- `LATENCY`, default 2: cycles from request sample to `dmem_resp`; legal range 1–15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `dmem_addr`  in  32: byte address; word index = `dmem_addr[2 +: $clog2(DEPTH_WORDS)]`; bits [1:0] ignored for indexing.
- `dmem_rmask`  in  4: byte read mask; nonzero = read request.
- `dmem_wmask`  in  4: byte write enables; nonzero = write request.
- `dmem_wdata`  in  32: write data, byte lanes aligned to the word.
- `dmem_rdata`  out  32: full word read; valid while `dmem_resp` = 1.
- `dmem_resp`  out  1: one-cycle response pulse.
- `dmem_err`  out  1: qualifies `dmem_resp`; out-of-range address.

## Operation
- States: IDLE, WAIT, RESP.
- **Request.** A request is present when `dmem_rmask | dmem_wmask` ≠ 0. It is sampled at a rising edge while in IDLE or RESP. At the sample, addr, rmask, wmask and wdata are latched internally, so inputs are don't-care until the next sampling state.
- **Sample transitions.**
  - LATENCY = 1: go to RESP.
  - Otherwise: go to WAIT with counter = LATENCY−1.
- **WAIT.** Counter decrements each edge. When counter = 1, the next edge enters RESP.
- **Commit edge** (the edge entering RESP):
  - Read: `dmem_rdata` ← mem[idx].
  - Write: mem[idx] byte b ← `wdata[8b+:8]` for each set `wmask[b]`.
  - Read and write both nonzero: `dmem_rdata` returns the pre-write word and the write is also performed.
- **Write-only request.** `dmem_rdata` ← 0.
- **Out of range.** Condition: `dmem_addr[31:2]` ≥ DEPTH_WORDS. No write occurs, `dmem_rdata` = 0, and `dmem_err` = 1 for the RESP cycle.
- **RESP.** `dmem_resp` = 1 for exactly one cycle. On the following edge:
  - new request present: accept it (back-to-back);
  - otherwise: go to IDLE.
- **Outputs outside RESP.** `dmem_resp` = 0 and `dmem_err` = 0. `dmem_rdata` holds its last value until the next commit.
- **Reset.** Memory contents are not reset; after reset they are undefined until written.

## Timing
- **Reset values:** state IDLE, counter 0, `dmem_resp` 0, `dmem_err` 0, `dmem_rdata` 0. All request latches clear.
- **Latency:** a request presented in cycle t is answered with `dmem_resp` high in cycle t+LATENCY.
- **Throughput:** one request per LATENCY cycles. A request presented during the RESP cycle is sampled at the end of that cycle.
- **Requests while in WAIT** are ignored. The initiator must not present a new request until it sees `dmem_resp`.
- **Read-after-write:** a read sampled in the RESP cycle of a write to the same word returns the written data.
- **Reset mid-operation:** asserting reset in WAIT drops the pending request. No response is issued, and no write occurs because the commit edge is never reached. Asserting reset in RESP forces `dmem_resp` low immediately (asynchronous); the commit already performed stands.
- **Counter:** width is `$clog2(LATENCY+1)`; it never underflows.

## Test plan
- **Reset then read.** Stimulus: reset low 3 cycles; release; write word 0x1 with `wmask`=4'hF, `wdata`=0xDEADBEEF, LATENCY=2; then read address 0x4. Required: resp high 2 cycles after each request, with `dmem_rdata`=0xDEADBEEF on the read resp.
- **Byte write merge.** Stimulus: write 0x11223344 to address 0x8, then `wmask`=4'b0100 with `wdata`=0x00AA0000, then read. Required: `dmem_rdata`=0x11AA3344.
- **Back-to-back.** Stimulus: LATENCY=1; present reads of 0x0, 0x4, 0x8 in consecutive cycles. Required: resp high for 3 consecutive cycles with the three words in order.
- **Out-of-range write/read.** Stimulus: DEPTH_WORDS=256; write to address 0x400, then read 0x400. Required: `dmem_err`=1 on both resp cycles, `dmem_rdata`=0, and the word at 0x0 is unchanged.
- **Reset during WAIT.** Stimulus: LATENCY=4; issue a write of 0xCAFEF00D to 0x10; assert reset 2 cycles later. Required: no resp; a later read of 0x10 returns the prior contents.
- **Simultaneous read+write.** Stimulus: word holds 0x5; request with rmask=wmask=4'hF and wdata 0x9. Required: `dmem_rdata`=0x5; a following read returns 0x9.
